smc_regfile: RTL and testbench
==============================

// Module: smc_regfile
// PURPOSE
// - Register-bus front end of the stepper motor controller (SMC): decodes QSEL/QWRITE/QADDR accesses, holds all SMC control registers.
// - Double-buffers duty-cycle and period registers; shadows transfer to active copies only at the PWM period boundary.
// - Feeds active register values to the downstream SMC PWM/output stage driving MNM/MNP; returns registered read data and timer-overflow IRQ.
// PARAMETERS
// - NCH     12  number of motor coil channels (MCCCn / MCDCn pairs)
// - DUTY_W  11  width of duty and period fields
// - ADDR_W  7   width of QADDR (word address)
// PORTS
// - QCLK        in   1          single clock; all state on posedge
// - QRESET      in   1          synchronous, active-low reset
// - QSEL        in   1          access strobe, one access per cycle
// - QWRITE      in   1          1 = write, 0 = read (valid with QSEL)
// - QADDR       in   ADDR_W     word address
// - QDATAIN     in   16         write data
// - QDATAOUT    out  16         read data, registered
// - period_end  in   1          one-cycle strobe from PWM timer at period wrap
// - mcctl0      out  8          MCCTL0 (bit7 MCTOIF reads as flag)
// - mcctl1      out  8          MCCTL1 (bit0 MCTOIE)
// - mcper_act   out  DUTY_W     active period
// - mccc_flat   out  NCH*8      MCCCn, channel n at [8n+7:8n]
// - mcdc_flat   out  NCH*16     active MCDCn, channel n at [16n+15:16n]
// - irq         out  1          MCTOIF & MCTOIE
// BEHAVIOUR
// - Reset (QRESET==0 at posedge): all registers, shadows, flag, QDATAOUT -> 0; irq -> 0. Reset overrides any access in the same cycle.
// - Map: 0x00 MCCTL0[7:0]; 0x01 MCCTL1[7:0]; 0x02 MCPER[DUTY_W-1:0]; 0x10+n MCCCn[7:0]; 0x20+n MCDCn {S[15], 4'b0, DUTY[10:0]}, n<NCH.
// - Unmapped addresses (incl. 0x10+n / 0x20+n with n>=NCH): writes ignored, reads return 0x0000.
// - Write (QSEL&QWRITE): data takes effect on the next posedge; unused/reserved bits stored as 0.
//   - MCCTL0[6:0], MCCTL1, MCCCn: direct, visible on outputs the cycle after write.
//   - MCCTL0[7] MCTOIF: write-1-to-clear; writing 0 has no effect.
//   - MCPER, MCDCn: write updates shadow only; active copy unchanged until period_end.
// - Transfer: on period_end, every active MCPER/MCDCn <= its shadow (all channels same cycle).
//   - Write to a shadow in the same cycle as period_end: active takes the NEW write data (bypass).
// - MCTOIF: set on period_end; set and W1C in same cycle -> flag stays 1 (set wins).
// - irq combinational from registered MCTOIF & MCTOIE; no extra latency.
// - Read (QSEL&~QWRITE): QDATAOUT valid one cycle after the access; holds last value when no read issued.
//   - MCPER/MCDCn reads return the SHADOW value; MCCTL0 read shows current MCTOIF in bit7.
//   - Read and write cannot overlap (single QWRITE); read returns pre-write value if same address written previous cycle? No: write lands first, read next cycle sees new value.
// - MCPER==0: stored and transferred normally; downstream treats it as channels off.
// - Reset mid-period: shadows and actives both cleared; next period_end transfers zeros.
// STRUCTURE
// - smc_pkg: address constants (SMC_MCCTL0_A, SMC_MCCTL1_A, SMC_MCPER_A, SMC_MCCC_BASE, SMC_MCDC_BASE), field positions (MCTOIF_BIT, MCTOIE_BIT, MCDC_SIGN_BIT), NCH/DUTY_W defaults.
// - Sub-module smc_dbuf: one shadow/active register pair with write-enable, transfer strobe, bypass rule; instantiated NCH+1 times (MCDCn + MCPER, width parameter).
// - Top: address decode, direct registers, MCTOIF logic, registered read mux.
// TESTING
// - Reset: write all regs, pulse QRESET low one cycle -> every output and QDATAOUT == 0, irq == 0.
// - Double buffer: write MCDC3=0x8123 -> mcdc_flat ch3 stays 0, read 0x23 returns 0x8123; pulse period_end -> ch3 == 0x8123.
// - Bypass: MCDC0=0x0100 committed; write MCDC0=0x0055 with period_end same cycle -> active ch0 == 0x0055 next cycle.
// - IRQ: MCCTL1=0x01, period_end -> MCTOIF=1, irq=1; write MCCTL0=0x80 -> irq=0; W1C with period_end same cycle -> irq stays 1.
// - Decode: write 0x2C (n=12) and 0x7F with 0xFFFF -> no output changes, reads return 0x0000; MCDC write 0xFFFF reads 0x87FF.
// - Read latency: back-to-back reads of 0x10,0x11 -> QDATAOUT shows MCCC0 then MCCC1, each one cycle after its QSEL.

Source files
------------

// File: rtl/smc_pkg.sv
// Shared address map, field positions and default sizes for the stepper motor controller register file.
// Pure constants; no logic, no latency.
package smc_pkg;

  localparam int SMC_NCH    = 12;
  localparam int SMC_DUTY_W = 11;
  localparam int SMC_ADDR_W = 7;

  localparam int SMC_MCCTL0_A  = 'h00;
  localparam int SMC_MCCTL1_A  = 'h01;
  localparam int SMC_MCPER_A   = 'h02;
  localparam int SMC_MCCC_BASE = 'h10;
  localparam int SMC_MCDC_BASE = 'h20;

  localparam int MCTOIF_BIT    = 7;
  localparam int MCTOIE_BIT    = 0;
  localparam int MCDC_SIGN_BIT = 15;

endpackage

// File: rtl/smc_dbuf.sv
// One shadow/active register pair: writes land in the shadow, the transfer strobe copies it to the active copy.
// A write coinciding with the transfer goes straight through to the active copy; no backpressure.
module smc_dbuf #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_wdat,
  input  logic         i_xfer,
  output logic [W-1:0] o_shadow,
  output logic [W-1:0] o_active
);

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_active;
  logic [W-1:0] w_next_shadow;

  assign w_next_shadow = i_we ? i_wdat : r_shadow;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      r_shadow <= w_next_shadow;
      if (i_xfer) r_active <= w_next_shadow;
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;

endmodule

// File: rtl/smc_regfile.sv
// SMC register-bus front end: decode, direct control regs, double-buffered period/duty, timer-overflow flag.
// Writes take effect next edge; read data registered one cycle after QSEL; always ready, no backpressure.
module smc_regfile
  import smc_pkg::*;
#(
  parameter int NCH    = SMC_NCH,
  parameter int DUTY_W = SMC_DUTY_W,
  parameter int ADDR_W = SMC_ADDR_W
) (
  input  logic                QCLK,
  input  logic                QRESET,
  input  logic                QSEL,
  input  logic                QWRITE,
  input  logic [ADDR_W-1:0]   QADDR,
  input  logic [15:0]         QDATAIN,
  output logic [15:0]         QDATAOUT,
  input  logic                period_end,
  output logic [7:0]          mcctl0,
  output logic [7:0]          mcctl1,
  output logic [DUTY_W-1:0]   mcper_act,
  output logic [NCH*8-1:0]    mccc_flat,
  output logic [NCH*16-1:0]   mcdc_flat,
  output logic                irq
);

  logic              w_wr;
  logic              w_rd;
  logic              w_ctl0_we;
  logic              w_ctl1_we;
  logic              w_per_we;
  logic [NCH-1:0]    w_mccc_we;
  logic [NCH-1:0]    w_mcdc_we;
  logic [DUTY_W-1:0] w_per_sh;
  logic [DUTY_W:0]   w_dc_sh  [NCH];
  logic [DUTY_W:0]   w_dc_act [NCH];
  logic [DUTY_W:0]   w_dc_wdat;
  logic [15:0]       w_rdata;
  logic              w_unused_dat;

  logic [6:0]        r_mcctl0_lo;
  logic              r_mctoif;
  logic [7:0]        r_mcctl1;
  logic [7:0]        r_mccc [NCH];
  logic [15:0]       r_qdataout;

  // Duty entries are stored compactly as {sign, duty}; the reserved bits between them read as 0.
  function automatic logic [15:0] mcdc_pack(input logic [DUTY_W:0] v);
    return {v[DUTY_W], {(15-DUTY_W){1'b0}}, v[DUTY_W-1:0]};
  endfunction

  assign w_wr         = QSEL & QWRITE;
  assign w_rd         = QSEL & ~QWRITE;
  assign w_ctl0_we    = w_wr && (QADDR == ADDR_W'(SMC_MCCTL0_A));
  assign w_ctl1_we    = w_wr && (QADDR == ADDR_W'(SMC_MCCTL1_A));
  assign w_per_we     = w_wr && (QADDR == ADDR_W'(SMC_MCPER_A));
  assign w_dc_wdat    = {QDATAIN[MCDC_SIGN_BIT], QDATAIN[DUTY_W-1:0]};
  assign w_unused_dat = ^QDATAIN[14:DUTY_W];

  smc_dbuf #(.W(DUTY_W)) u_per (
    .i_clk    (QCLK),
    .i_rst_n  (QRESET),
    .i_we     (w_per_we),
    .i_wdat   (QDATAIN[DUTY_W-1:0]),
    .i_xfer   (period_end),
    .o_shadow (w_per_sh),
    .o_active (mcper_act)
  );

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign w_mccc_we[n] = w_wr && (QADDR == ADDR_W'(SMC_MCCC_BASE + n));
    assign w_mcdc_we[n] = w_wr && (QADDR == ADDR_W'(SMC_MCDC_BASE + n));

    smc_dbuf #(.W(DUTY_W + 1)) u_dc (
      .i_clk    (QCLK),
      .i_rst_n  (QRESET),
      .i_we     (w_mcdc_we[n]),
      .i_wdat   (w_dc_wdat),
      .i_xfer   (period_end),
      .o_shadow (w_dc_sh[n]),
      .o_active (w_dc_act[n])
    );

    assign mccc_flat[8*n +: 8]   = r_mccc[n];
    assign mcdc_flat[16*n +: 16] = mcdc_pack(w_dc_act[n]);
  end

  // Period wrap sets the overflow flag even if software clears it in the same cycle.
  always_ff @(posedge QCLK) begin
    if (!QRESET) begin
      r_mcctl0_lo <= '0;
      r_mctoif    <= 1'b0;
      r_mcctl1    <= '0;
      for (int i = 0; i < NCH; i++) r_mccc[i] <= '0;
    end else begin
      if (w_ctl0_we) r_mcctl0_lo <= QDATAIN[6:0];
      if (period_end)                              r_mctoif <= 1'b1;
      else if (w_ctl0_we && QDATAIN[MCTOIF_BIT])   r_mctoif <= 1'b0;
      if (w_ctl1_we) r_mcctl1 <= QDATAIN[7:0];
      for (int i = 0; i < NCH; i++) begin
        if (w_mccc_we[i]) r_mccc[i] <= QDATAIN[7:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (QADDR == ADDR_W'(SMC_MCCTL0_A)) w_rdata = {8'h00, r_mctoif, r_mcctl0_lo};
    if (QADDR == ADDR_W'(SMC_MCCTL1_A)) w_rdata = {8'h00, r_mcctl1};
    if (QADDR == ADDR_W'(SMC_MCPER_A))  w_rdata = {{(16-DUTY_W){1'b0}}, w_per_sh};
    for (int i = 0; i < NCH; i++) begin
      if (QADDR == ADDR_W'(SMC_MCCC_BASE + i)) w_rdata = {8'h00, r_mccc[i]};
      if (QADDR == ADDR_W'(SMC_MCDC_BASE + i)) w_rdata = mcdc_pack(w_dc_sh[i]);
    end
  end

  always_ff @(posedge QCLK) begin
    if (!QRESET)   r_qdataout <= '0;
    else if (w_rd) r_qdataout <= w_rdata;
  end

  assign QDATAOUT = r_qdataout;
  assign mcctl0   = {r_mctoif, r_mcctl0_lo};
  assign mcctl1   = r_mcctl1;
  assign irq      = r_mctoif & r_mcctl1[MCTOIE_BIT];

endmodule

// File: tb/tb_smc_regfile.sv
// Directed plus randomized bench for smc_regfile against a register-map level reference model.
module tb_smc_regfile;

  localparam int NCH = 12;

  logic         QCLK = 1'b0;
  logic         QRESET = 1'b0;
  logic         QSEL = 1'b0;
  logic         QWRITE = 1'b0;
  logic [6:0]   QADDR = '0;
  logic [15:0]  QDATAIN = '0;
  logic [15:0]  QDATAOUT;
  logic         period_end = 1'b0;
  logic [7:0]   mcctl0;
  logic [7:0]   mcctl1;
  logic [10:0]  mcper_act;
  logic [95:0]  mccc_flat;
  logic [191:0] mcdc_flat;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 QCLK = ~QCLK;

  smc_regfile dut (
    .QCLK       (QCLK),
    .QRESET     (QRESET),
    .QSEL       (QSEL),
    .QWRITE     (QWRITE),
    .QADDR      (QADDR),
    .QDATAIN    (QDATAIN),
    .QDATAOUT   (QDATAOUT),
    .period_end (period_end),
    .mcctl0     (mcctl0),
    .mcctl1     (mcctl1),
    .mcper_act  (mcper_act),
    .mccc_flat  (mccc_flat),
    .mcdc_flat  (mcdc_flat),
    .irq        (irq)
  );

  // Reference model: registers held in their read-back format.
  logic [6:0]  m_ctl0;
  logic        m_flag;
  logic [7:0]  m_ctl1;
  logic [15:0] m_per_sh, m_per_act;
  logic [7:0]  m_mccc [NCH];
  logic [15:0] m_dc_sh [NCH];
  logic [15:0] m_dc_act [NCH];
  logic [15:0] m_qdo;

  function automatic logic [15:0] m_read(input logic [6:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {8'h00, m_flag, m_ctl0};
    if (ai == 1) return {8'h00, m_ctl1};
    if (ai == 2) return m_per_sh;
    if (ai >= 'h10 && ai < 'h10 + NCH) return {8'h00, m_mccc[ai - 'h10]};
    if (ai >= 'h20 && ai < 'h20 + NCH) return m_dc_sh[ai - 'h20];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_ctl0 = '0; m_flag = 1'b0; m_ctl1 = '0;
    m_per_sh = '0; m_per_act = '0; m_qdo = '0;
    for (int i = 0; i < NCH; i++) begin
      m_mccc[i] = '0; m_dc_sh[i] = '0; m_dc_act[i] = '0;
    end
  endtask

  task automatic model_edge(input logic rst_n, sel, wr, input logic [6:0] a,
                            input logic [15:0] d, input logic pe);
    int ai;
    ai = int'(a);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (sel && !wr) m_qdo = m_read(a);
    if (sel && wr) begin
      if (ai == 0) begin
        m_ctl0 = d[6:0];
        if (d[7]) m_flag = 1'b0;
      end
      if (ai == 1) m_ctl1 = d[7:0];
      if (ai == 2) m_per_sh = d & 16'h07FF;
      if (ai >= 'h10 && ai < 'h10 + NCH) m_mccc[ai - 'h10] = d[7:0];
      if (ai >= 'h20 && ai < 'h20 + NCH) m_dc_sh[ai - 'h20] = d & 16'h87FF;
    end
    if (pe) begin
      m_flag = 1'b1;
      m_per_act = m_per_sh;
      for (int i = 0; i < NCH; i++) m_dc_act[i] = m_dc_sh[i];
    end
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [95:0]  e_mccc;
    logic [191:0] e_mcdc;
    for (int i = 0; i < NCH; i++) begin
      e_mccc[8*i +: 8]   = m_mccc[i];
      e_mcdc[16*i +: 16] = m_dc_act[i];
    end
    chk("mcctl0",    192'(mcctl0),    192'({m_flag, m_ctl0}));
    chk("mcctl1",    192'(mcctl1),    192'(m_ctl1));
    chk("mcper_act", 192'(mcper_act), 192'(m_per_act[10:0]));
    chk("mccc_flat", 192'(mccc_flat), 192'(e_mccc));
    chk("mcdc_flat", mcdc_flat,       e_mcdc);
    chk("irq",       192'(irq),       192'(m_flag & m_ctl1[0]));
    chk("qdataout",  192'(QDATAOUT),  192'(m_qdo));
  endtask

  task automatic step(input logic rst_n, sel, wr, input logic [6:0] a,
                      input logic [15:0] d, input logic pe);
    @(negedge QCLK);
    QRESET = rst_n; QSEL = sel; QWRITE = wr; QADDR = a; QDATAIN = d; period_end = pe;
    @(posedge QCLK);
    model_edge(rst_n, sel, wr, a, d, pe);
    #1;
    check_all();
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [15:0] d, input logic pe);
    step(1'b1, 1'b1, 1'b1, a, d, pe);
  endtask

  task automatic rd_reg(input logic [6:0] a);
    step(1'b1, 1'b1, 1'b0, a, 16'h0000, 1'b0);
  endtask

  task automatic idle(input logic pe);
    step(1'b1, 1'b0, 1'b0, 7'h00, 16'h0000, pe);
  endtask

  initial begin
    logic [6:0]  ra;
    logic [15:0] rdat;
    int          k;

    model_reset();
    step(1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 7'h01, 16'hFFFF, 1'b1);
    chk("reset_qdo", 192'(QDATAOUT), 192'(16'h0000));

    // Load everything, then reset.
    wr_reg(7'h00, 16'h007F, 1'b0);
    wr_reg(7'h01, 16'h0001, 1'b0);
    wr_reg(7'h02, 16'h03FF, 1'b0);
    for (int i = 0; i < NCH; i++) begin
      wr_reg(7'(8'h10 + i), 16'(16'h00A0 + i), 1'b0);
      wr_reg(7'(8'h20 + i), 16'(16'h8010 + i), 1'b0);
    end
    idle(1'b1);
    rd_reg(7'h25);
    chk("preload_irq", 192'(irq), 192'(1'b1));
    step(1'b0, 1'b1, 1'b1, 7'h00, 16'h0080, 1'b0);
    chk("reset_irq",  192'(irq), 192'(1'b0));
    chk("reset_mcdc", mcdc_flat, 192'(0));
    chk("reset_mccc", 192'(mccc_flat), 192'(0));
    idle(1'b1);
    chk("reset_xfer_zero", 192'(mcper_act), 192'(0));

    // Double buffer.
    wr_reg(7'h23, 16'h8123, 1'b0);
    chk("dbuf_hold", 192'(mcdc_flat[63:48]), 192'(16'h0000));
    rd_reg(7'h23);
    chk("dbuf_shadow_rd", 192'(QDATAOUT), 192'(16'h8123));
    idle(1'b1);
    chk("dbuf_xfer", 192'(mcdc_flat[63:48]), 192'(16'h8123));

    // Bypass on coincident write and period_end.
    wr_reg(7'h20, 16'h0100, 1'b0);
    idle(1'b1);
    chk("bypass_pre", 192'(mcdc_flat[15:0]), 192'(16'h0100));
    wr_reg(7'h20, 16'h0055, 1'b1);
    chk("bypass_new", 192'(mcdc_flat[15:0]), 192'(16'h0055));

    // Overflow flag and interrupt.
    wr_reg(7'h00, 16'h0080, 1'b0);
    wr_reg(7'h01, 16'h0001, 1'b0);
    chk("irq_clear", 192'(irq), 192'(1'b0));
    idle(1'b1);
    chk("irq_set", 192'(irq), 192'(1'b1));
    wr_reg(7'h00, 16'h0000, 1'b0);
    chk("irq_w0_keep", 192'(irq), 192'(1'b1));
    wr_reg(7'h00, 16'h0080, 1'b0);
    chk("irq_w1c", 192'(irq), 192'(1'b0));
    wr_reg(7'h00, 16'h0080, 1'b1);
    chk("irq_set_wins", 192'(irq), 192'(1'b1));

    // Decode boundaries.
    wr_reg(7'h2C, 16'hFFFF, 1'b0);
    wr_reg(7'h1C, 16'hFFFF, 1'b0);
    wr_reg(7'h7F, 16'hFFFF, 1'b1);
    rd_reg(7'h2C);
    chk("unmapped_2c", 192'(QDATAOUT), 192'(16'h0000));
    rd_reg(7'h7F);
    chk("unmapped_7f", 192'(QDATAOUT), 192'(16'h0000));
    wr_reg(7'h21, 16'hFFFF, 1'b0);
    rd_reg(7'h21);
    chk("mcdc_mask", 192'(QDATAOUT), 192'(16'h87FF));
    wr_reg(7'h02, 16'hFFFF, 1'b0);
    rd_reg(7'h02);
    chk("mcper_mask", 192'(QDATAOUT), 192'(16'h07FF));

    // Read latency and hold.
    wr_reg(7'h10, 16'h12A5, 1'b0);
    wr_reg(7'h11, 16'h345A, 1'b0);
    rd_reg(7'h10);
    chk("rd_mccc0", 192'(QDATAOUT), 192'(16'h00A5));
    rd_reg(7'h11);
    chk("rd_mccc1", 192'(QDATAOUT), 192'(16'h005A));
    idle(1'b0);
    chk("rd_hold", 192'(QDATAOUT), 192'(16'h005A));

    // Zero period transfers normally.
    wr_reg(7'h02, 16'h0000, 1'b1);
    chk("mcper_zero", 192'(mcper_act), 192'(0));

    // Randomized traffic.
    for (int t = 0; t < 600; t++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0)      ra = 7'h00;
      else if (k == 1) ra = 7'h01;
      else if (k == 2) ra = 7'h02;
      else if (k <= 5) ra = 7'(8'h10 + $urandom_range(0, 13));
      else if (k <= 8) ra = 7'(8'h20 + $urandom_range(0, 13));
      else             ra = 7'($urandom_range(0, 127));
      rdat = 16'($urandom);
      step($urandom_range(0, 99) >= 2, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), ra, rdat, $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
